// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared definitions for the min:sec countdown timer: state encodings and BCD digit limits.
// The display stage imports the same package so both sides agree on encodings.
package countdown_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } timer_state_t;

    localparam logic [3:0] BCD_TENS_MAX = 4'd5;
    localparam logic [3:0] BCD_ONES_MAX = 4'd9;

endpackage

// File: rtl/countdown_timer_ctrl_bcd60_step.sv
// Combinational mod-60 BCD step on {tens,ones}: +1 when dec=0, -1 when dec=1.
// wrap flags 59->00 on increment and 00->59 on decrement (carry/borrow out).
module bcd60_step
    import countdown_timer_ctrl_pkg::*;
(
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       dec,
    output logic [3:0] next_tens,
    output logic [3:0] next_ones,
    output logic       wrap
);

    always_comb begin
        next_tens = tens;
        next_ones = ones;
        wrap      = 1'b0;
        if (dec) begin
            if (ones == 4'd0) begin
                next_ones = BCD_ONES_MAX;
                if (tens == 4'd0) begin
                    next_tens = BCD_TENS_MAX;
                    wrap      = 1'b1;
                end else begin
                    next_tens = tens - 4'd1;
                end
            end else begin
                next_ones = ones - 4'd1;
            end
        end else begin
            if (ones >= BCD_ONES_MAX) begin
                next_ones = 4'd0;
                if (tens >= BCD_TENS_MAX) begin
                    next_tens = 4'd0;
                    wrap      = 1'b1;
                end else begin
                    next_tens = tens + 4'd1;
                end
            end else begin
                next_ones = ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Kitchen min:sec countdown timer: button-driven setup, 1 s tick countdown, timed alarm.
// state | meaning
// IDLE  | stopped, digits editable, start needs nonzero time
// RUN   | counting down on tick_sec, reaching 00:00 raises the alarm
// PAUSE | digits held, editable, start resumes if nonzero
// ALARM | alarm high for ALARM_SEC ticks or until any button
module countdown_timer_ctrl
    import countdown_timer_ctrl_pkg::*;
#(
    parameter int ALARM_SEC = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_sec,
    input  logic       btn_start,
    input  logic       btn_inc_min,
    input  logic       btn_inc_sec,
    input  logic       btn_clear,
    output logic [3:0] sec1,
    output logic [3:0] sec10,
    output logic [3:0] min1,
    output logic [3:0] min10,
    output logic       running,
    output logic       alarm,
    output logic [1:0] state
);

    timer_state_t st;
    logic [5:0]   alarm_cnt;
    logic [3:0]   sec10_nxt, sec1_nxt, min10_nxt, min1_nxt;
    logic         sec_wrap, min_wrap;
    logic         dec_mode, time_zero, last_tick, any_btn;

    assign dec_mode  = (st == ST_RUN);
    assign time_zero = ({min10, min1, sec10, sec1} == 16'h0000);
    assign last_tick = ({min10, min1, sec10, sec1} == 16'h0001);
    assign any_btn   = btn_start | btn_inc_min | btn_inc_sec | btn_clear;
    assign state     = st;

    bcd60_step u_sec_step (
        .tens      (sec10),
        .ones      (sec1),
        .dec       (dec_mode),
        .next_tens (sec10_nxt),
        .next_ones (sec1_nxt),
        .wrap      (sec_wrap)
    );

    // Minutes step on their own when incrementing, and only on a seconds borrow when counting down.
    bcd60_step u_min_step (
        .tens      (min10),
        .ones      (min1),
        .dec       (dec_mode),
        .next_tens (min10_nxt),
        .next_ones (min1_nxt),
        .wrap      (min_wrap)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st        <= ST_IDLE;
            {min10, min1, sec10, sec1} <= 16'h0000;
            running   <= 1'b0;
            alarm     <= 1'b0;
            alarm_cnt <= 6'd0;
        end else begin
            case (st)
                ST_IDLE, ST_PAUSE: begin
                    if (btn_clear) begin
                        st      <= ST_IDLE;
                        running <= 1'b0;
                        {min10, min1, sec10, sec1} <= 16'h0000;
                    end else if (btn_start) begin
                        if (!time_zero) begin
                            st      <= ST_RUN;
                            running <= 1'b1;
                        end
                    end else if (btn_inc_min) begin
                        {min10, min1} <= {min10_nxt, min1_nxt};
                    end else if (btn_inc_sec) begin
                        {sec10, sec1} <= {sec10_nxt, sec1_nxt};
                    end
                end
                ST_RUN: begin
                    if (btn_clear) begin
                        st      <= ST_IDLE;
                        running <= 1'b0;
                        {min10, min1, sec10, sec1} <= 16'h0000;
                    end else if (btn_start) begin
                        st      <= ST_PAUSE;
                        running <= 1'b0;
                    end else if (tick_sec) begin
                        // A borrow out of 00:00 cannot occur from RUN; treat it as expiry anyway.
                        if (last_tick || (sec_wrap && min_wrap)) begin
                            st        <= ST_ALARM;
                            running   <= 1'b0;
                            alarm     <= 1'b1;
                            alarm_cnt <= 6'(ALARM_SEC);
                            {min10, min1, sec10, sec1} <= 16'h0000;
                        end else begin
                            {sec10, sec1} <= {sec10_nxt, sec1_nxt};
                            if (sec_wrap)
                                {min10, min1} <= {min10_nxt, min1_nxt};
                        end
                    end
                end
                ST_ALARM: begin
                    {min10, min1, sec10, sec1} <= 16'h0000;
                    if (any_btn || (tick_sec && alarm_cnt <= 6'd1)) begin
                        st        <= ST_IDLE;
                        alarm     <= 1'b0;
                        alarm_cnt <= 6'd0;
                    end else if (tick_sec) begin
                        alarm_cnt <= alarm_cnt - 6'd1;
                    end
                end
                default: begin
                    st        <= ST_IDLE;
                    running   <= 1'b0;
                    alarm     <= 1'b0;
                    alarm_cnt <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench for countdown_timer_ctrl: stimulus queues hand-computed expectations,
// a monitor pops and compares one entry after every clock edge.
module tb_countdown_timer_ctrl;

    localparam logic [4:0] B_CLR = 5'b10000;
    localparam logic [4:0] B_STA = 5'b01000;
    localparam logic [4:0] B_MIN = 5'b00100;
    localparam logic [4:0] B_SEC = 5'b00010;
    localparam logic [4:0] B_TCK = 5'b00001;
    localparam logic [4:0] B_NON = 5'b00000;
    localparam logic [1:0] S_I = 2'd0;
    localparam logic [1:0] S_R = 2'd1;
    localparam logic [1:0] S_P = 2'd2;
    localparam logic [1:0] S_A = 2'd3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_sec = 1'b0, btn_start = 1'b0, btn_inc_min = 1'b0;
    logic       btn_inc_sec = 1'b0, btn_clear = 1'b0;
    logic [3:0] sec1, sec10, min1, min10;
    logic       running, alarm;
    logic [1:0] state;

    typedef struct {
        int         id;
        logic       chk;
        logic [1:0] st;
        logic [15:0] t;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   step_id = 0;

    always #5 clk = ~clk;

    countdown_timer_ctrl #(.ALARM_SEC(10)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick_sec    (tick_sec),
        .btn_start   (btn_start),
        .btn_inc_min (btn_inc_min),
        .btn_inc_sec (btn_inc_sec),
        .btn_clear   (btn_clear),
        .sec1        (sec1),
        .sec10       (sec10),
        .min1        (min1),
        .min10       (min10),
        .running     (running),
        .alarm       (alarm),
        .state       (state)
    );

    function automatic logic [7:0] bcd(input int v);
        bcd = {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic cmp(input int id, input logic [1:0] st, input logic [15:0] t);
        logic [19:0] act, req;
        act = {state, running, alarm, min10, min1, sec10, sec1};
        req = {st, (st == S_R), (st == S_A), t};
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL step%0d: got state=%0d run=%0b alarm=%0b time=%h, expected state=%0d run=%0b alarm=%0b time=%h",
                     id, act[19:18], act[17], act[16], act[15:0],
                     req[19:18], req[17], req[16], req[15:0]);
        end
    endtask

    task automatic step(input logic [4:0] b, input logic chk, input logic [1:0] st, input logic [15:0] t);
        @(negedge clk);
        {btn_clear, btn_start, btn_inc_min, btn_inc_sec, tick_sec} = b;
        step_id++;
        q.push_back('{step_id, chk, st, t});
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk)
                    cmp(e.id, e.st, e.t);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        cmp(0, S_I, 16'h0000);
        reset_n = 1'b1;
        step(B_NON, 1, S_I, 16'h0000);

        // setup and countdown
        step(B_SEC, 1, S_I, 16'h0001);
        step(B_SEC, 1, S_I, 16'h0002);
        step(B_SEC, 1, S_I, 16'h0003);
        step(B_MIN, 1, S_I, 16'h0103);
        step(B_MIN, 1, S_I, 16'h0203);
        step(B_STA, 1, S_R, 16'h0203);
        step(B_TCK, 1, S_R, 16'h0202);
        step(B_NON, 1, S_R, 16'h0202);
        step(B_TCK, 1, S_R, 16'h0201);
        step(B_TCK, 1, S_R, 16'h0200);

        // minute borrow, then expiry into ALARM
        step(B_CLR, 1, S_I, 16'h0000);
        step(B_MIN, 1, S_I, 16'h0100);
        step(B_STA, 1, S_R, 16'h0100);
        step(B_TCK, 1, S_R, 16'h0059);
        step(B_CLR, 1, S_I, 16'h0000);
        step(B_SEC, 1, S_I, 16'h0001);
        step(B_STA, 1, S_R, 16'h0001);
        step(B_TCK, 1, S_A, 16'h0000);

        // alarm times out on the 10th tick
        step(B_NON, 1, S_A, 16'h0000);
        for (int i = 1; i <= 10; i++)
            step(B_TCK, 1, (i < 10) ? S_A : S_I, 16'h0000);

        // alarm cut short by a button
        step(B_SEC, 1, S_I, 16'h0001);
        step(B_STA, 1, S_R, 16'h0001);
        step(B_TCK, 1, S_A, 16'h0000);
        step(B_TCK, 1, S_A, 16'h0000);
        step(B_TCK, 1, S_A, 16'h0000);
        step(B_CLR, 1, S_I, 16'h0000);

        // pause with simultaneous tick, ticks ignored while paused
        for (int i = 1; i <= 5; i++)
            step(B_SEC, 1, S_I, {8'h00, bcd(i)});
        step(B_STA, 1, S_R, 16'h0005);
        step(B_STA | B_TCK, 1, S_P, 16'h0005);
        step(B_TCK, 1, S_P, 16'h0005);
        step(B_TCK, 1, S_P, 16'h0005);
        step(B_STA, 1, S_R, 16'h0005);
        step(B_TCK, 1, S_R, 16'h0004);
        step(B_STA, 1, S_P, 16'h0004);
        step(B_SEC, 1, S_P, 16'h0005);
        step(B_CLR, 1, S_I, 16'h0000);

        // wraps without carry, start ignored at 00:00, priority among inc buttons
        for (int i = 1; i <= 59; i++)
            step(B_SEC, 1, S_I, {8'h00, bcd(i)});
        step(B_SEC, 1, S_I, 16'h0000);
        step(B_STA, 1, S_I, 16'h0000);
        for (int i = 1; i <= 59; i++)
            step(B_MIN, 1, S_I, {bcd(i), 8'h00});
        step(B_MIN, 1, S_I, 16'h0000);
        step(B_MIN | B_SEC, 1, S_I, 16'h0100);
        step(B_CLR | B_MIN | B_SEC, 1, S_I, 16'h0000);

        // 10:00 -> 09:59
        for (int i = 1; i <= 10; i++)
            step(B_MIN, 1, S_I, {bcd(i), 8'h00});
        step(B_STA, 1, S_R, 16'h1000);
        step(B_TCK, 1, S_R, 16'h0959);
        step(B_CLR, 1, S_I, 16'h0000);

        // async reset mid-count
        for (int i = 1; i <= 12; i++)
            step(B_MIN, 1, S_I, {bcd(i), 8'h00});
        for (int i = 1; i <= 34; i++)
            step(B_SEC, 1, S_I, {8'h12, bcd(i)});
        step(B_STA, 1, S_R, 16'h1234);
        step(B_TCK, 1, S_R, 16'h1233);
        step(B_NON, 1, S_R, 16'h1233);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 cmp(-1, S_I, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        step(B_TCK, 1, S_I, 16'h0000);

        // clear beats start in RUN
        step(B_SEC, 1, S_I, 16'h0001);
        step(B_SEC, 1, S_I, 16'h0002);
        step(B_STA, 1, S_R, 16'h0002);
        step(B_CLR | B_STA, 1, S_I, 16'h0000);
        step(B_NON, 1, S_I, 16'h0000);

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
